// File: rtl/lift_motion_ctrl.sv
// rtl/lift_motion_ctrl.sv - per-car lift motion controller
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   tgt_floor/valid target floor from dispatcher, valid/ready handshake
//   tgt_ready       high when IDLE and not halted
//   halt            freezes all timers and state; motor forced to stop
//   motor_signal    00 stop, 01 up, 10 down
//   door_open       high in DOOR_OPEN (also while halted there)
//   cur_floor       current car floor
//   arrived         one-cycle pulse on reaching the target
//   tgt_err         one-cycle pulse when an out-of-range target is accepted
//   busy            controller not IDLE
module lift_motion_ctrl #(
  parameter int FLOORS        = 11,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOOR_W-1:0] tgt_floor,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic               halt,
  output logic [1:0]         motor_signal,
  output logic               door_open,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               arrived,
  output logic               tgt_err,
  output logic               busy
);

  // Counter widths never drop to zero, even for a 1-cycle parameter.
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR_OPEN = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] cur_q, cur_d;
  logic [FLOOR_W-1:0] tgt_q, tgt_d;
  logic [TW-1:0]      trav_q, trav_d;
  logic [DW-1:0]      door_q, door_d;
  logic               arrived_q, arrived_d;
  logic               err_q, err_d;

  logic [FLOOR_W-1:0] step_floor;
  logic               out_of_range;

  // Range check one bit wider so FLOORS == 2**FLOOR_W does not wrap.
  assign out_of_range = ({1'b0, tgt_floor} >= (FLOOR_W + 1)'(FLOORS));
  assign step_floor   = (state_q == MOVE_UP) ? cur_q + FLOOR_W'(1)
                                             : cur_q - FLOOR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      tgt_q     <= '0;
      trav_q    <= '0;
      door_q    <= '0;
      arrived_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      trav_q    <= trav_d;
      door_q    <= door_d;
      arrived_q <= arrived_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    trav_d    = trav_q;
    door_d    = door_q;
    arrived_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid && !halt) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else if (tgt_floor == cur_q) begin
            state_d   = DOOR_OPEN;
            door_d    = '0;
            arrived_d = 1'b1;
          end else begin
            state_d = (tgt_floor > cur_q) ? MOVE_UP : MOVE_DOWN;
            tgt_d   = tgt_floor;
            trav_d  = '0;
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (!halt) begin
          if (trav_q == TRAV_LAST) begin
            trav_d = '0;
            cur_d  = step_floor;
            if (step_floor == tgt_q) begin
              state_d   = DOOR_OPEN;
              door_d    = '0;
              arrived_d = 1'b1;
            end
          end else begin
            trav_d = trav_q + TW'(1);
          end
        end
      end
      DOOR_OPEN: begin
        if (!halt) begin
          if (door_q == DOOR_LAST) begin
            state_d = IDLE;
          end else begin
            door_d = door_q + DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tgt_ready    = (state_q == IDLE) && !halt;
  assign motor_signal = halt                   ? 2'b00 :
                        (state_q == MOVE_UP)   ? 2'b01 :
                        (state_q == MOVE_DOWN) ? 2'b10 : 2'b00;
  assign door_open    = (state_q == DOOR_OPEN);
  assign busy         = (state_q != IDLE);
  assign cur_floor    = cur_q;
  assign arrived      = arrived_q;
  assign tgt_err      = err_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// tb/tb_lift_motion_ctrl.sv - self-checking bench for lift_motion_ctrl
module tb_lift_motion_ctrl;

  localparam int FL = 11;
  localparam int T  = 8;
  localparam int D  = 4;

  logic       clk;
  logic       rst;
  logic [3:0] tgt_floor;
  logic       tgt_valid;
  logic       tgt_ready;
  logic       halt;
  logic [1:0] motor_signal;
  logic       door_open;
  logic [3:0] cur_floor;
  logic       arrived;
  logic       tgt_err;
  logic       busy;

  lift_motion_ctrl #(.FLOORS(FL), .FLOOR_W(4), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .tgt_floor(tgt_floor), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .halt(halt), .motor_signal(motor_signal),
    .door_open(door_open), .cur_floor(cur_floor), .arrived(arrived),
    .tgt_err(tgt_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an accepted target expands into the full per-cycle
  // trace of expected outputs; each unhalted edge consumes one entry.
  typedef struct {
    logic [1:0] motor;
    int         floor;
    bit         door;
    bit         arr;
  } ent_t;

  ent_t q[$];
  int   m_floor;
  bit   m_fresh;
  bit   m_err;
  int   n_assert;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_floor = 0;
    m_fresh = 0;
    m_err   = 0;
  endtask

  task automatic model_edge(input bit v, input int f, input bit h);
    ent_t e;
    int   d;
    int   dir;
    m_err   = 0;
    m_fresh = 0;
    if (q.size() != 0) begin
      if (!h) begin
        void'(q.pop_front());
        m_fresh = 1;
      end
    end else if (v && !h) begin
      if (f >= FL) begin
        m_err = 1;
      end else begin
        dir = (f > m_floor) ? 1 : -1;
        d   = (f > m_floor) ? f - m_floor : m_floor - f;
        for (int i = 0; i < d * T; i++) begin
          e.motor = (dir > 0) ? 2'b01 : 2'b10;
          e.floor = m_floor + dir * (i / T);
          e.door  = 0;
          e.arr   = 0;
          q.push_back(e);
        end
        for (int j = 0; j < D; j++) begin
          e.motor = 2'b00;
          e.floor = f;
          e.door  = 1;
          e.arr   = (j == 0);
          q.push_back(e);
        end
        m_floor = f;
        m_fresh = 1;
      end
    end
  endtask

  task automatic check_outputs(input bit h);
    if (q.size() == 0) begin
      chk("cur_floor", 32'(cur_floor), 32'(m_floor));
      chk("motor", 32'(motor_signal), 0);
      chk("door_open", 32'(door_open), 0);
      chk("arrived", 32'(arrived), 0);
      chk("busy", 32'(busy), 0);
      chk("tgt_ready", 32'(tgt_ready), 32'(!h));
    end else begin
      chk("cur_floor", 32'(cur_floor), 32'(q[0].floor));
      chk("motor", 32'(motor_signal), h ? 0 : 32'(q[0].motor));
      chk("door_open", 32'(door_open), 32'(q[0].door));
      chk("arrived", 32'(arrived), 32'(q[0].arr && m_fresh));
      chk("busy", 32'(busy), 1);
      chk("tgt_ready", 32'(tgt_ready), 0);
    end
    chk("tgt_err", 32'(tgt_err), 32'(m_err));
  endtask

  task automatic cycle(input bit v, input int f, input bit h);
    @(negedge clk);
    tgt_valid = v;
    tgt_floor = 4'(f);
    halt      = h;
    @(posedge clk);
    model_edge(v, f, h);
    #1;
    check_outputs(h);
  endtask

  task automatic go(input int f);
    cycle(1, f, 0);
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle(0, 0, 0);
    chk("drain", 32'(q.size()), 0);
  endtask

  int arr_edge;

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    halt      = 1'b0;
    tgt_valid = 1'b0;
    tgt_floor = 4'd0;
    model_reset();
    #12;
    chk("rst_floor", 32'(cur_floor), 0);
    chk("rst_motor", 32'(motor_signal), 0);
    chk("rst_door", 32'(door_open), 0);
    chk("rst_ready", 32'(tgt_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_arrived", 32'(arrived), 0);
    chk("rst_err", 32'(tgt_err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) cycle(0, 0, 0);

    // Directed moves: up, down, same floor, out of range, back to 0.
    go(3);
    go(1);
    go(2);
    go(2);
    go(12);
    go(0);

    // Halt for 5 cycles mid-move 0 -> 2; arrival must land on edge 21.
    arr_edge = -1;
    cycle(1, 2, 0);
    for (int e = 1; e <= 40; e++) begin
      cycle(0, 0, (e >= 7 && e <= 11));
      if (arrived === 1'b1 && arr_edge < 0) arr_edge = e;
    end
    chk("halt_arrive_edge", 32'(arr_edge), 21);

    // Randomized traffic, including out-of-range targets and halts.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 13)),
            ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 300 && q.size() != 0; i++) cycle(0, 0, 0);
    chk("rand_drain", 32'(q.size()), 0);
    if (m_floor != 5) go(5);

    // Asynchronous reset mid-move re-homes the car to floor 0.
    cycle(1, 9, 0);
    repeat (10) cycle(0, 0, 0);
    chk("pre_rst_motor", 32'(motor_signal), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_motor", 32'(motor_signal), 0);
    chk("async_rst_floor", 32'(cur_floor), 0);
    chk("async_rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) cycle(0, 0, 0);
    go(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
